// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer.
// Steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction and drives the
// datapath strobes, immediate format select, memory handshake with a wait
// timeout, and a retired-instruction counter.
// Optional feature macro: TRAP_ILLEGAL_EN (illegal opcodes take a one-cycle
// TRAP to the trap vector instead of retiring as a NOP).
// Strobes are decoded from the state register (and mem_ready for the
// same-cycle handshake) and are forced low while rst_n is asserted.
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT_CYC = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic [2:0]           imm_sel,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state_o,
    output logic                 instr_retired,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halted,
    output logic                 illegal_insn
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

`ifdef TRAP_ILLEGAL_EN
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5,
        S_HALT      = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd6
    } state_t;
`endif

    typedef enum logic [3:0] {
        IC_OP      = 4'd0,
        IC_UPPER   = 4'd1,
        IC_JAL     = 4'd2,
        IC_JALR    = 4'd3,
        IC_BRANCH  = 4'd4,
        IC_LOAD    = 4'd5,
        IC_STORE   = 4'd6,
        IC_OPIMM   = 4'd7,
        IC_NOP     = 4'd8,
        IC_ILLEGAL = 4'd9
    } iclass_t;

    // Map a major opcode to the instruction class the sequencer acts on.
    function automatic iclass_t classify(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC:    classify = IC_UPPER;
            OPC_JAL:               classify = IC_JAL;
            OPC_JALR:              classify = IC_JALR;
            OPC_BRANCH:            classify = IC_BRANCH;
            OPC_LOAD:              classify = IC_LOAD;
            OPC_STORE:             classify = IC_STORE;
            OPC_OPIMM:             classify = IC_OPIMM;
            OPC_OP:                classify = IC_OP;
            OPC_FENCE, OPC_SYSTEM: classify = IC_NOP;
            default:               classify = IC_ILLEGAL;
        endcase
    endfunction

    // Immediate extender format for a class: 0 I, 1 S, 2 B, 3 U, 4 J.
    function automatic logic [2:0] imm_format(input iclass_t c);
        case (c)
            IC_UPPER:  imm_format = 3'd3;
            IC_JAL:    imm_format = 3'd4;
            IC_BRANCH: imm_format = 3'd2;
            IC_STORE:  imm_format = 3'd1;
            default:   imm_format = 3'd0;
        endcase
    endfunction

    state_t                 state_r, state_n;
    logic [CNT_W-1:0]       tmo_cnt_r;
    logic [2:0]             imm_sel_r;
    logic [INSTRET_W-1:0]   instret_r;
    logic                   halted_r;

    iclass_t                iclass_s;
    logic                   mem_req_s, mem_we_s, ir_we_s, pc_we_s, reg_we_s;
    logic                   retire_s, illegal_s;
    logic [1:0]             pc_src_s, wb_sel_s;
    logic                   wait_s, tmo_hit_s;

    assign iclass_s  = classify(opcode);
    assign wait_s    = mem_req_s & ~mem_ready;
    assign tmo_hit_s = wait_s && (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode and datapath strobes for the current state.
    always_comb begin
        state_n   = state_r;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        ir_we_s   = 1'b0;
        pc_we_s   = 1'b0;
        pc_src_s  = 2'd0;
        reg_we_s  = 1'b0;
        wb_sel_s  = 2'd0;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_we_s = 1'b1;
                    state_n = S_DECODE;
                end else if (tmo_hit_s) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_DECODE: begin
`ifdef TRAP_ILLEGAL_EN
                if (iclass_s == IC_ILLEGAL) begin
                    state_n = S_TRAP;
                end else begin
                    state_n = S_EXECUTE;
                end
`else
                state_n = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                case (iclass_s)
                    IC_BRANCH: begin
                        pc_we_s  = 1'b1;
                        pc_src_s = branch_taken ? 2'd1 : 2'd0;
                        retire_s = 1'b1;
                        state_n  = S_FETCH;
                    end
                    IC_LOAD, IC_STORE: begin
                        state_n = S_MEMORY;
                    end
                    IC_NOP, IC_ILLEGAL: begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_n  = S_FETCH;
                    end
                    default: begin
                        state_n = S_WRITEBACK;
                    end
                endcase
            end
            S_MEMORY: begin
                mem_req_s = 1'b1;
                mem_we_s  = (iclass_s == IC_STORE);
                if (mem_ready) begin
                    if (iclass_s == IC_STORE) begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_n  = S_FETCH;
                    end else begin
                        state_n = S_WRITEBACK;
                    end
                end else if (tmo_hit_s) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_MEMORY;
                end
            end
            S_WRITEBACK: begin
                reg_we_s = 1'b1;
                pc_we_s  = 1'b1;
                retire_s = 1'b1;
                state_n  = S_FETCH;
                case (iclass_s)
                    IC_LOAD: begin
                        wb_sel_s = 2'd1;
                    end
                    IC_JAL: begin
                        wb_sel_s = 2'd2;
                        pc_src_s = 2'd1;
                    end
                    IC_JALR: begin
                        wb_sel_s = 2'd2;
                        pc_src_s = 2'd2;
                    end
                    default: begin
                        wb_sel_s = 2'd0;
                    end
                endcase
            end
`ifdef TRAP_ILLEGAL_EN
            S_TRAP: begin
                illegal_s = 1'b1;
                pc_we_s   = 1'b1;
                pc_src_s  = 2'd3;
                state_n   = S_FETCH;
            end
`endif
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // Consecutive memory-wait counter; any cycle without a stalled request clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (wait_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Immediate format latched in DECODE and held for the rest of the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_sel_r <= 3'd0;
        end else if (state_r == S_DECODE) begin
            imm_sel_r <= imm_format(iclass_s);
        end else begin
            imm_sel_r <= imm_sel_r;
        end
    end

    // Retired-instruction counter, wrapping at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + INSTRET_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Sticky bus-error flag, set on entry to HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else if (state_n == S_HALT) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    assign mem_req       = mem_req_s & rst_n;
    assign mem_we        = mem_we_s  & rst_n;
    assign ir_we         = ir_we_s   & rst_n;
    assign pc_we         = pc_we_s   & rst_n;
    assign pc_src        = pc_src_s  & {2{rst_n}};
    assign reg_we        = reg_we_s  & rst_n;
    assign wb_sel        = wb_sel_s  & {2{rst_n}};
    assign instr_retired = retire_s  & rst_n;
`ifdef TRAP_ILLEGAL_EN
    assign illegal_insn  = illegal_s & rst_n;
`else
    assign illegal_insn  = 1'b0;
`endif
    assign imm_sel       = imm_sel_r;
    assign instret       = instret_r;
    assign halted        = halted_r;
    assign state_o       = state_r;

endmodule
